// File: rtl/axilite_mem_dualch_if.sv
// AXI4-Lite bus bundle for axilite_mem_dualch: five channels, with master and slave views.
interface axilite_mem_dualch_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    awvalid;
  logic                    awready;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    wvalid;
  logic                    wready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    bvalid;
  logic                    bready;
  logic [1:0]              bresp;
  logic                    arvalid;
  logic                    arready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    rvalid;
  logic                    rready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axilite_mem_dualch.sv
// AXI4-Lite slave scratch memory with independent read/write FSMs, byte strobes,
// configurable read latency, SLVERR on bad addresses and a saturating error counter.
module axilite_mem_dualch #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_SIZE_BYTES = 64,
  parameter int RD_LATENCY     = 0,
  parameter int ERR_CNT_WIDTH  = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  axilite_mem_dualch_if.slave      s_axi,
  output logic [ERR_CNT_WIDTH-1:0] err_count
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int WORDS  = MEM_SIZE_BYTES / STRB_W;
  localparam int IDX_W  = (WORDS > 1) ? $clog2(WORDS) : 1;

  localparam logic [ADDR_WIDTH-1:0] MEM_LIMIT = ADDR_WIDTH'(MEM_SIZE_BYTES);
  localparam logic [3:0]            LAT       = 4'(RD_LATENCY);
  localparam logic [1:0]            RESP_OKAY   = 2'b00;
  localparam logic [1:0]            RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA}   r_state_t;

  logic [DATA_WIDTH-1:0] mem [WORDS];

  // ---------------- write channel ----------------
  w_state_t              w_state, w_state_nx;
  logic                  aw_held, aw_held_nx, w_held, w_held_nx;
  logic                  awready_q, awready_nx, wready_q, wready_nx;
  logic                  bvalid_q, bvalid_nx;
  logic [1:0]            bresp_q, bresp_nx;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]     wstrb_q;
  logic                  aw_hs, w_hs, b_hs, aw_err, w_commit;
  logic [IDX_W-1:0]      w_idx;

  assign aw_hs  = s_axi.awvalid && awready_q;
  assign w_hs   = s_axi.wvalid && wready_q;
  assign b_hs   = bvalid_q && s_axi.bready;
  assign aw_err = (awaddr_q >= MEM_LIMIT) || (awaddr_q[LSB-1:0] != '0);
  assign w_idx  = awaddr_q[LSB +: IDX_W];

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nx = w_state;
    aw_held_nx = aw_held;
    w_held_nx  = w_held;
    bvalid_nx  = bvalid_q;
    bresp_nx   = bresp_q;
    w_commit   = 1'b0;
    unique case (w_state)
      W_IDLE: begin
        if (aw_hs) aw_held_nx = 1'b1;
        if (w_hs)  w_held_nx  = 1'b1;
        if (aw_held && w_held) w_state_nx = W_COMMIT;
      end
      W_COMMIT: begin
        w_commit   = 1'b1;
        bvalid_nx  = 1'b1;
        bresp_nx   = aw_err ? RESP_SLVERR : RESP_OKAY;
        w_state_nx = W_RESP;
      end
      W_RESP: begin
        if (b_hs) begin
          bvalid_nx  = 1'b0;
          aw_held_nx = 1'b0;
          w_held_nx  = 1'b0;
          w_state_nx = W_IDLE;
        end
      end
      default: w_state_nx = W_IDLE;
    endcase
    // Readies are registered: each follows whether its channel can accept next cycle.
    awready_nx = (w_state_nx == W_IDLE) && !aw_held_nx;
    wready_nx  = (w_state_nx == W_IDLE) && !w_held_nx;
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      w_state   <= W_IDLE;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      w_state   <= w_state_nx;
      aw_held   <= aw_held_nx;
      w_held    <= w_held_nx;
      awready_q <= awready_nx;
      wready_q  <= wready_nx;
      bvalid_q  <= bvalid_nx;
      bresp_q   <= bresp_nx;
      if (aw_hs) awaddr_q <= s_axi.awaddr;
      if (w_hs) begin
        wdata_q <= s_axi.wdata;
        wstrb_q <= s_axi.wstrb;
      end
    end
  end

  // NOTE: the array is built from flops and cleared on reset; a RAM macro could not be.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      for (int i = 0; i < WORDS; i++) mem[i] <= '0;
    end else if (w_commit && !aw_err) begin
      for (int b = 0; b < STRB_W; b++)
        if (wstrb_q[b]) mem[w_idx][8*b +: 8] <= wdata_q[8*b +: 8];
    end
  end

  // ---------------- read channel ----------------
  r_state_t              r_state, r_state_nx;
  logic                  ar_held, ar_held_nx;
  logic                  arready_q, arready_nx;
  logic                  rvalid_q, rvalid_nx;
  logic [3:0]            rd_cnt, rd_cnt_nx;
  logic [1:0]            rresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [ADDR_WIDTH-1:0] araddr_q;
  logic                  ar_hs, r_hs, ar_err, r_sample;
  logic [IDX_W-1:0]      r_idx;

  assign ar_hs  = s_axi.arvalid && arready_q;
  assign r_hs   = rvalid_q && s_axi.rready;
  assign ar_err = (araddr_q >= MEM_LIMIT) || (araddr_q[LSB-1:0] != '0);
  assign r_idx  = araddr_q[LSB +: IDX_W];

  // The cycle after AR capture is always spent in R_IDLE with the address held;
  // R_WAIT then adds exactly RD_LATENCY cycles before the data is sampled.
  always_comb begin
    r_state_nx = r_state;
    ar_held_nx = ar_held;
    rvalid_nx  = rvalid_q;
    rd_cnt_nx  = rd_cnt;
    r_sample   = 1'b0;
    unique case (r_state)
      R_IDLE: begin
        if (ar_held) begin
          ar_held_nx = 1'b0;
          if (RD_LATENCY == 0) begin
            r_sample   = 1'b1;
            rvalid_nx  = 1'b1;
            r_state_nx = R_DATA;
          end else begin
            rd_cnt_nx  = 4'd1;
            r_state_nx = R_WAIT;
          end
        end else if (ar_hs) begin
          ar_held_nx = 1'b1;
        end
      end
      R_WAIT: begin
        if (rd_cnt == LAT) begin
          r_sample   = 1'b1;
          rvalid_nx  = 1'b1;
          r_state_nx = R_DATA;
        end else begin
          rd_cnt_nx = rd_cnt + 4'd1;
        end
      end
      R_DATA: begin
        if (r_hs) begin
          rvalid_nx  = 1'b0;
          r_state_nx = R_IDLE;
        end
      end
      default: r_state_nx = R_IDLE;
    endcase
    arready_nx = (r_state_nx == R_IDLE) && !ar_held_nx;
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_state   <= R_IDLE;
      ar_held   <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rd_cnt    <= '0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
      araddr_q  <= '0;
    end else begin
      r_state   <= r_state_nx;
      ar_held   <= ar_held_nx;
      arready_q <= arready_nx;
      rvalid_q  <= rvalid_nx;
      rd_cnt    <= rd_cnt_nx;
      if (ar_hs) araddr_q <= s_axi.araddr;
      // Sampling here sees memory before any commit landing on the same edge.
      if (r_sample) begin
        rdata_q <= ar_err ? '0 : mem[r_idx];
        rresp_q <= ar_err ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  // ---------------- error counter ----------------
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_nx;
  logic [ERR_CNT_WIDTH:0]   err_sum;
  logic [1:0]               err_inc;

  always_comb begin
    err_inc    = {1'b0, b_hs && (bresp_q == RESP_SLVERR)}
               + {1'b0, r_hs && (rresp_q == RESP_SLVERR)};
    err_sum    = {1'b0, err_cnt_q} + (ERR_CNT_WIDTH + 1)'(err_inc);
    err_cnt_nx = err_sum[ERR_CNT_WIDTH] ? '1 : err_sum[ERR_CNT_WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) err_cnt_q <= '0;
    else      err_cnt_q <= err_cnt_nx;
  end

  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;
  assign err_count     = err_cnt_q;

endmodule

// File: tb/tb_axilite_mem_dualch.sv
// Directed bench for axilite_mem_dualch (32-bit data, 64-byte memory, RD_LATENCY=3).
module tb_axilite_mem_dualch;

  localparam int TIMEOUT = 50;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] err_count;
  int         errors = 0;
  int         checks = 0;

  axilite_mem_dualch_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) s_axi ();

  axilite_mem_dualch #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_SIZE_BYTES(64),
    .RD_LATENCY(3), .ERR_CNT_WIDTH(8)
  ) dut (
    .clk(clk), .rstn(rstn), .s_axi(s_axi), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_b(output logic [1:0] resp);
    for (int n = 0; n < TIMEOUT && !s_axi.bvalid; n++) tick();
    check("bvalid_seen", s_axi.bvalid, 1'b1);
    resp = s_axi.bresp;
    s_axi.bready = 1'b1;
    tick();
    s_axi.bready = 1'b0;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    logic aw_done, w_done, aw_hs, w_hs;
    aw_done = 1'b0;
    w_done  = 1'b0;
    s_axi.awaddr = addr;  s_axi.awvalid = 1'b1;
    s_axi.wdata  = data;  s_axi.wstrb   = strb;  s_axi.wvalid = 1'b1;
    for (int n = 0; n < TIMEOUT && !(aw_done && w_done); n++) begin
      aw_hs = s_axi.awvalid && s_axi.awready;
      w_hs  = s_axi.wvalid && s_axi.wready;
      tick();
      if (aw_hs) begin aw_done = 1'b1; s_axi.awvalid = 1'b0; end
      if (w_hs)  begin w_done  = 1'b1; s_axi.wvalid  = 1'b0; end
    end
    s_axi.awvalid = 1'b0;
    s_axi.wvalid  = 1'b0;
    check("wr_accepted", {aw_done, w_done}, 2'b11);
    wait_b(resp);
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    logic ar_done, ar_hs;
    ar_done = 1'b0;
    s_axi.araddr = addr;
    s_axi.arvalid = 1'b1;
    for (int n = 0; n < TIMEOUT && !ar_done; n++) begin
      ar_hs = s_axi.arready;
      tick();
      if (ar_hs) ar_done = 1'b1;
    end
    s_axi.arvalid = 1'b0;
    check("rd_accepted", ar_done, 1'b1);
    for (int n = 0; n < TIMEOUT && !s_axi.rvalid; n++) tick();
    check("rvalid_seen", s_axi.rvalid, 1'b1);
    data = s_axi.rdata;
    resp = s_axi.rresp;
    s_axi.rready = 1'b1;
    tick();
    s_axi.rready = 1'b0;
  endtask

  // Error write to 0x44 and error read from 0x40, both responses retired on one edge.
  task automatic dual_err();
    logic ar_done, aw_done, w_done, ar_hs, aw_hs, w_hs;
    ar_done = 1'b0; aw_done = 1'b0; w_done = 1'b0;
    s_axi.araddr = 32'h40; s_axi.arvalid = 1'b1;
    s_axi.awaddr = 32'h44; s_axi.awvalid = 1'b1;
    s_axi.wdata  = 32'hFFFF_FFFF; s_axi.wstrb = 4'hF; s_axi.wvalid = 1'b1;
    for (int n = 0; n < TIMEOUT && !(ar_done && aw_done && w_done); n++) begin
      ar_hs = s_axi.arvalid && s_axi.arready;
      aw_hs = s_axi.awvalid && s_axi.awready;
      w_hs  = s_axi.wvalid && s_axi.wready;
      tick();
      if (ar_hs) begin ar_done = 1'b1; s_axi.arvalid = 1'b0; end
      if (aw_hs) begin aw_done = 1'b1; s_axi.awvalid = 1'b0; end
      if (w_hs)  begin w_done  = 1'b1; s_axi.wvalid  = 1'b0; end
    end
    s_axi.arvalid = 1'b0; s_axi.awvalid = 1'b0; s_axi.wvalid = 1'b0;
    for (int n = 0; n < TIMEOUT && !(s_axi.bvalid && s_axi.rvalid); n++) tick();
    check("dual_both_valid", {s_axi.bvalid, s_axi.rvalid}, 2'b11);
    s_axi.bready = 1'b1;
    s_axi.rready = 1'b1;
    tick();
    s_axi.bready = 1'b0;
    s_axi.rready = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic [1:0]  resp;
    logic        hs;

    rstn = 1'b1;
    s_axi.awvalid = 1'b0; s_axi.awaddr = '0;
    s_axi.wvalid  = 1'b0; s_axi.wdata  = '0; s_axi.wstrb = '0;
    s_axi.bready  = 1'b0;
    s_axi.arvalid = 1'b0; s_axi.araddr = '0;
    s_axi.rready  = 1'b0;

    // Reset state
    repeat (5) tick();
    check("rst_readies", {s_axi.awready, s_axi.wready, s_axi.arready}, 3'b000);
    check("rst_valids", {s_axi.bvalid, s_axi.rvalid}, 2'b00);
    check("rst_resps", {s_axi.bresp, s_axi.rresp}, 4'h0);
    check("rst_rdata", s_axi.rdata, 32'h0);
    check("rst_err_count", err_count, 8'h00);
    rstn = 1'b0;
    tick();
    check("readies_after_release", {s_axi.awready, s_axi.wready, s_axi.arready}, 3'b111);
    axi_read(32'h00, rd, resp);
    check("rd0_data", rd, 32'h0000_0000);
    check("rd0_resp", resp, 2'b00);

    // Byte strobes
    axi_write(32'h04, 32'hAAAA_AAAA, 4'b0011, resp);
    check("strb_lo_bresp", resp, 2'b00);
    axi_write(32'h04, 32'h5555_5555, 4'b1100, resp);
    check("strb_hi_bresp", resp, 2'b00);
    axi_read(32'h04, rd, resp);
    check("strb_merge_data", rd, 32'h5555_AAAA);

    // W ahead of AW by three cycles
    s_axi.wdata = 32'h1234_5678; s_axi.wstrb = 4'hF; s_axi.wvalid = 1'b1;
    hs = s_axi.wready;
    tick();
    s_axi.wvalid = 1'b0;
    check("w_first_hs", hs, 1'b1);
    check("w_first_ready", {s_axi.wready, s_axi.awready}, 2'b01);
    tick();
    tick();
    check("w_first_no_b", s_axi.bvalid, 1'b0);
    s_axi.awaddr = 32'h08; s_axi.awvalid = 1'b1;
    hs = s_axi.awready;
    tick();
    s_axi.awvalid = 1'b0;
    check("aw_late_hs", hs, 1'b1);
    check("b_after_aw_0", s_axi.bvalid, 1'b0);
    tick();
    check("b_after_aw_1", s_axi.bvalid, 1'b0);
    tick();
    check("b_after_aw_2", s_axi.bvalid, 1'b1);
    check("b_after_aw_resp", s_axi.bresp, 2'b00);

    // B backpressure: response held, no new AW accepted
    s_axi.awaddr = 32'h0C; s_axi.awvalid = 1'b1;
    repeat (3) tick();
    check("b_hold_valid", s_axi.bvalid, 1'b1);
    check("b_hold_no_aw", s_axi.awready, 1'b0);
    s_axi.awvalid = 1'b0;
    s_axi.bready = 1'b1;
    tick();
    s_axi.bready = 1'b0;
    check("b_released", s_axi.bvalid, 1'b0);
    axi_read(32'h08, rd, resp);
    check("order_readback", rd, 32'h1234_5678);
    axi_read(32'h0C, rd, resp);
    check("blocked_aw_no_write", rd, 32'h0);

    // Address errors
    axi_write(32'h40, 32'hDEAD_BEEF, 4'hF, resp);
    check("oor_wr_bresp", resp, 2'b10);
    axi_read(32'h12, rd, resp);
    check("misal_rd_rresp", resp, 2'b10);
    check("misal_rd_rdata", rd, 32'h0);
    check("err_count_2", err_count, 8'd2);
    axi_read(32'h00, rd, resp);
    check("oor_wr_no_alias", rd, 32'h0);
    axi_write(32'h05, 32'hFFFF_FFFF, 4'hF, resp);
    check("misal_wr_bresp", resp, 2'b10);
    axi_read(32'h04, rd, resp);
    check("misal_wr_no_update", rd, 32'h5555_AAAA);
    check("err_count_3", err_count, 8'd3);
    axi_write(32'h3C, 32'hA5A5_0F0F, 4'hF, resp);
    check("last_word_bresp", resp, 2'b00);
    axi_read(32'h3C, rd, resp);
    check("last_word_data", rd, 32'hA5A5_0F0F);
    check("last_word_rresp", resp, 2'b00);

    // Read latency 3 and R backpressure
    s_axi.araddr = 32'h08; s_axi.arvalid = 1'b1;
    hs = s_axi.arready;
    tick();
    s_axi.arvalid = 1'b0;
    check("lat_ar_hs", hs, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("lat_rvalid_low", s_axi.rvalid, 1'b0);
    end
    tick();
    check("lat_rvalid_edge4", s_axi.rvalid, 1'b1);
    check("lat_rdata", s_axi.rdata, 32'h1234_5678);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("r_hold", {s_axi.rvalid, s_axi.rdata, s_axi.rresp}, {1'b1, 32'h1234_5678, 2'b00});
    end
    s_axi.rready = 1'b1;
    tick();
    s_axi.rready = 1'b0;
    check("r_released", s_axi.rvalid, 1'b0);

    // Read sample and write commit on the same edge
    s_axi.araddr = 32'h00; s_axi.arvalid = 1'b1;
    hs = s_axi.arready;
    tick();
    s_axi.arvalid = 1'b0;
    check("race_ar_hs", hs, 1'b1);
    tick();
    s_axi.awaddr = 32'h00; s_axi.awvalid = 1'b1;
    s_axi.wdata = 32'hCAFE_F00D; s_axi.wstrb = 4'hF; s_axi.wvalid = 1'b1;
    hs = s_axi.awready && s_axi.wready;
    tick();
    s_axi.awvalid = 1'b0;
    s_axi.wvalid = 1'b0;
    check("race_aw_w_hs", hs, 1'b1);
    tick();
    check("race_not_yet", {s_axi.rvalid, s_axi.bvalid}, 2'b00);
    tick();
    check("race_both_valid", {s_axi.rvalid, s_axi.bvalid}, 2'b11);
    check("race_old_data", s_axi.rdata, 32'h0);
    s_axi.rready = 1'b1;
    s_axi.bready = 1'b1;
    tick();
    s_axi.rready = 1'b0;
    s_axi.bready = 1'b0;
    axi_read(32'h00, rd, resp);
    check("race_new_data", rd, 32'hCAFE_F00D);

    // Reset while a write response is pending
    s_axi.awaddr = 32'h10; s_axi.awvalid = 1'b1;
    s_axi.wdata = 32'h1111_2222; s_axi.wstrb = 4'hF; s_axi.wvalid = 1'b1;
    tick();
    s_axi.awvalid = 1'b0;
    s_axi.wvalid = 1'b0;
    for (int n = 0; n < TIMEOUT && !s_axi.bvalid; n++) tick();
    check("pre_rst_bvalid", s_axi.bvalid, 1'b1);
    rstn = 1'b1;
    #1;
    check("rst_bvalid_drop", s_axi.bvalid, 1'b0);
    check("rst_err_cleared", err_count, 8'h00);
    tick();
    tick();
    rstn = 1'b0;
    tick();
    axi_read(32'h08, rd, resp);
    check("rst_mem_cleared_08", rd, 32'h0);
    axi_read(32'h10, rd, resp);
    check("rst_mem_cleared_10", rd, 32'h0);

    // Simultaneous error handshakes and saturation (300 error reads in total)
    dual_err();
    check("dual_add_2", err_count, 8'd2);
    for (int k = 0; k < 252; k++) axi_read(32'h40, rd, resp);
    check("err_count_fe", err_count, 8'hFE);
    dual_err();
    check("dual_saturate", err_count, 8'hFF);
    for (int k = 0; k < 46; k++) axi_read(32'h40, rd, resp);
    check("err_count_sat", err_count, 8'hFF);
    check("sat_last_rresp", resp, 2'b10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
